// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: op encoding, FCLASS bit positions and decoded operand fields.
package fpu_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;

    localparam logic [31:0] FP_CANON_NAN = 32'h7fc00000;

    typedef enum logic [2:0] {
        OpFeq    = 3'd0,
        OpFlt    = 3'd1,
        OpFle    = 3'd2,
        OpFclass = 3'd3,
        OpFmin   = 3'd4,
        OpFmax   = 3'd5
    } fp_op_e;

    localparam int unsigned ClsNegInf  = 0;
    localparam int unsigned ClsNegNorm = 1;
    localparam int unsigned ClsNegSub  = 2;
    localparam int unsigned ClsNegZero = 3;
    localparam int unsigned ClsPosZero = 4;
    localparam int unsigned ClsPosSub  = 5;
    localparam int unsigned ClsPosNorm = 6;
    localparam int unsigned ClsPosInf  = 7;
    localparam int unsigned ClsSNan    = 8;
    localparam int unsigned ClsQNan    = 9;

    typedef struct packed {
        logic sign;
        logic exp_all1;
        logic exp_zero;
        logic mant_zero;
        logic quiet;
    } fp_fields_t;

    function automatic logic fp_is_nan(input fp_fields_t f);
        return f.exp_all1 & ~f.mant_zero;
    endfunction

    function automatic logic fp_is_snan(input fp_fields_t f);
        return fp_is_nan(f) & ~f.quiet;
    endfunction

    function automatic logic fp_is_zero(input fp_fields_t f);
        return f.exp_zero & f.mant_zero;
    endfunction

    function automatic logic [9:0] fp_classify(input fp_fields_t f);
        logic [9:0] c;
        logic       inf;
        logic       sub;
        logic       norm;
        inf  = f.exp_all1 & f.mant_zero;
        sub  = f.exp_zero & ~f.mant_zero;
        norm = ~f.exp_all1 & ~f.exp_zero;
        c             = '0;
        c[ClsNegInf]  = inf & f.sign;
        c[ClsNegNorm] = norm & f.sign;
        c[ClsNegSub]  = sub & f.sign;
        c[ClsNegZero] = fp_is_zero(f) & f.sign;
        c[ClsPosZero] = fp_is_zero(f) & ~f.sign;
        c[ClsPosSub]  = sub & ~f.sign;
        c[ClsPosNorm] = norm & ~f.sign;
        c[ClsPosInf]  = inf & ~f.sign;
        c[ClsSNan]    = fp_is_snan(f);
        c[ClsQNan]    = fp_is_nan(f) & f.quiet;
        return c;
    endfunction

endpackage

// File: rtl/fp_field_decode.sv
// Combinational split of an IEEE-754 single into the flags the compare/classify stage needs.
module fp_field_decode
    import fpu_pkg::*;
(
    input  logic [31:0] val_i,
    output fp_fields_t  fields_o
);

    always_comb begin
        fields_o.sign      = val_i[31];
        fields_o.exp_all1  = &val_i[30:MANT_W];
        fields_o.exp_zero  = ~|val_i[30:MANT_W];
        fields_o.mant_zero = ~|val_i[MANT_W-1:0];
        fields_o.quiet     = val_i[MANT_W-1];
    end

endmodule

// File: rtl/fcmp_class.sv
// Two-stage FP compare / classify / min-max unit with valid-ready on both sides.
// Optional invalid-operation flag output `nv` when FCMP_NV_FLAG_EN is defined.
module fcmp_class
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] tag_in,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] tag_out
`ifdef FCMP_NV_FLAG_EN
    ,
    output logic             nv
`endif
);

    fp_fields_t fa_d, fb_d;

    fp_field_decode u_dec_a (
        .val_i    (x1),
        .fields_o (fa_d)
    );

    fp_field_decode u_dec_b (
        .val_i    (x2),
        .fields_o (fb_d)
    );

    logic             s1_valid_q;
    logic [2:0]       s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [31:0]      s1_a_q, s1_b_q;
    fp_fields_t       s1_fa_q, s1_fb_q;

    logic             s2_valid_q;
    logic [31:0]      y_q, y_d;
    logic [TAG_W-1:0] tag_out_q;

    logic s2_load;
    logic accept;

    assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_load;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_fa_q    <= '0;
            s1_fb_q    <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (accept) begin
                s1_op_q  <= op;
                s1_tag_q <= tag_in;
                s1_a_q   <= x1;
                s1_b_q   <= x2;
                s1_fa_q  <= fa_d;
                s1_fb_q  <= fb_d;
            end
        end
    end

    logic a_nan, b_nan, any_nan, any_snan;
    logic both_zero, eq, lt, lt_ord;

    always_comb begin
        a_nan     = fp_is_nan(s1_fa_q);
        b_nan     = fp_is_nan(s1_fb_q);
        any_nan   = a_nan | b_nan;
        any_snan  = fp_is_snan(s1_fa_q) | fp_is_snan(s1_fb_q);
        both_zero = fp_is_zero(s1_fa_q) & fp_is_zero(s1_fb_q);
        eq        = (s1_a_q == s1_b_q) | both_zero;
        lt        = (s1_fa_q.sign & ~s1_fb_q.sign & ~both_zero)
                  | (~s1_fa_q.sign & ~s1_fb_q.sign & (s1_a_q[30:0] < s1_b_q[30:0]))
                  | (s1_fa_q.sign & s1_fb_q.sign & (s1_a_q[30:0] > s1_b_q[30:0]));
        // min/max order -0 strictly below +0
        lt_ord    = lt | (both_zero & s1_fa_q.sign & ~s1_fb_q.sign);

        y_d = '0;
        case (s1_op_q)
            OpFeq:    y_d = {31'b0, eq & ~any_nan};
            OpFlt:    y_d = {31'b0, lt & ~any_nan};
            OpFle:    y_d = {31'b0, (lt | eq) & ~any_nan};
            OpFclass: y_d = {22'b0, fp_classify(s1_fa_q)};
            OpFmin, OpFmax: begin
                if (a_nan && b_nan) begin
                    y_d = FP_CANON_NAN;
                end else if (a_nan) begin
                    y_d = s1_b_q;
                end else if (b_nan) begin
                    y_d = s1_a_q;
                end else if (s1_op_q == OpFmin) begin
                    y_d = lt_ord ? s1_a_q : s1_b_q;
                end else begin
                    y_d = lt_ord ? s1_b_q : s1_a_q;
                end
            end
            default:  y_d = '0;
        endcase
    end

`ifdef FCMP_NV_FLAG_EN
    logic nv_q, nv_d;

    always_comb begin
        nv_d = 1'b0;
        case (s1_op_q)
            OpFlt, OpFle:         nv_d = any_nan;
            OpFeq, OpFmin, OpFmax: nv_d = any_snan;
            default:              nv_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nv_q <= 1'b0;
        end else if (s2_load) begin
            nv_q <= nv_d;
        end
    end

    assign nv = nv_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            tag_out_q  <= '0;
        end else if (s2_load) begin
            s2_valid_q <= 1'b1;
            y_q        <= y_d;
            tag_out_q  <= s1_tag_q;
        end else if (out_ready) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign tag_out   = tag_out_q;

endmodule

// File: doc/fcmp_class.md
Name: fcmp_class

Overview:
- Pipelined FPU reader for IEEE-754 single-precision operands: comparisons (feq/flt/fle), classification (fclass) and fmin/fmax.
- Counterpart to the sign-injection writers: it decodes the sign, exponent and mantissa fields that those units compose.
- Sits in the FPU execute stage beside the sign-injection units, behind a valid/ready handshake toward the writeback arbiter.

Parameters:
- TAG_W, 4, width of the opaque tag carried alongside each op (destination register id).

Ports:
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  op presented.
- in_ready  out  1  unit accepts op this cycle.
- op  in  3  0 FEQ, 1 FLT, 2 FLE, 3 FCLASS, 4 FMIN, 5 FMAX; 6/7 reserved.
- tag_in  in  TAG_W  passthrough tag.
- x1  in  32  operand a.
- x2  in  32  operand b; ignored for FCLASS.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- y  out  32  result.
- tag_out  out  TAG_W  tag of the current result.
- nv  out  1  invalid-operation flag; present only with FCMP_NV_FLAG_EN.

Behaviour:
- Reset is asynchronous. While rstn=0: out_valid=0, y=0, tag_out=0, nv=0, both stage valids=0.
- Reset mid-operation drops all in-flight ops with no output.
- Pipeline has two registered stages:
  - S1: field decode of x1/x2; registers op, tag and decoded fields.
  - S2: result compute; registers y/tag_out.
- Latency is 2 cycles from accept to out_valid when out_ready is held 1. Throughput is 1 op/cycle.
- Handshake:
  - Accept when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - S2 loads when S1 is valid and (S2 is empty or out_ready).
  - in_ready = ~s1_valid | s2_load. It is combinational and never depends on in_valid.
- Simultaneous accept and output transfer on a full pipe: both happen, no bubble, no loss, results in order.
- out_valid and y are held stable while out_ready=0.
- Compare results: y={31'b0, bit}.
  - FEQ: +0 equals -0. Any NaN gives 0.
  - FLT/FLE: signed-magnitude order; ±0 are equal. Any NaN gives 0.
  - lt = (sa & ~sb & ~bothzero) | (~sa & ~sb & mag_a<mag_b) | (sa & sb & mag_a>mag_b), where mag = bits[30:0].
- FCLASS: y = one-hot in bits[9:0], upper bits 0.
  - bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0.
  - bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf.
  - bit8 sNaN, bit9 qNaN.
  - A NaN is quiet when mantissa bit 22 = 1.
- FMIN/FMAX:
  - -0 orders below +0.
  - One NaN operand: return the other operand.
  - Both NaN: return canonical 0x7fc00000.
- Reserved op: y=0, still produces out_valid (no hang).

Optional Feature:
- FCMP_NV_FLAG_EN defined:
  - nv port exists and is registered with y.
  - nv=1 for FLT/FLE with any NaN operand.
  - nv=1 for FEQ/FMIN/FMAX with any sNaN operand.
  - nv=0 otherwise, and for FCLASS.
- Not defined: nv port and its logic are absent; results are unchanged.

Decomposition:
- Shared package fpu_pkg:
  - op enum (FEQ..FMAX).
  - FCLASS bit-position constants.
  - FP_CANON_NAN=32'h7fc00000.
  - EXP_W=8, MANT_W=23.
  - struct for decoded fields: sign, exp_all1, exp_zero, mant_zero, quiet.
- Sub-module fp_field_decode: combinational, one instance per operand, used in S1.

Test Plan:
- FEQ x1=0x00000000, x2=0x80000000, out_ready=1 -> y=0x00000001 exactly 2 cycles after accept; nv=0.
- FLT 0x3f800000 vs 0x40000000 -> y=1. FLE 0x7fc00000 vs 0x3f800000 -> y=0, nv=1.
- FCLASS back-to-back on 0xff800000, 0x00000001, 0x7f800001 -> y=0x001, 0x020, 0x100 on consecutive cycles.
- FMIN(0x80000000, 0x00000000) -> 0x80000000.
- FMAX(0x7fc00000, 0x3f800000) -> 0x3f800000.
- FMAX(0x7fc00000, 0xffc00000) -> 0x7fc00000.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 with tags 1,2,3 -> in_ready falls after 2 accepts; on release, tags come out 1,2,3 with no loss or duplication.
- Reset mid-op: assert rstn=0 with both stages valid -> out_valid=0 immediately (asynchronous). After release, in_ready=1 and the first new op returns in 2 cycles.
